// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per req/ack handshake,
// holds it for the decoder until downstream retires it, then selects the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       op_code,
    output logic [5:0]       funct,
    output logic             instr_valid,
    input  logic             instr_accept,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             load_s;
    logic             retire_s;
    logic [31:0]      pc_plus4_s;
    logic [31:0]      jump_tgt_s;
    logic [31:0]      br_off_s;
    logic [31:0]      br_tgt_s;
    logic [31:0]      next_pc_s;

    // State register and datapath registers; reset wins over any pending ack/accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_accept) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Per-state strobes: ack only matters in FETCH, accept only in HOLD.
    always_comb begin
        load_s   = 1'b0;
        retire_s = 1'b0;
        case (state_q)
            ST_FETCH: load_s   = imem_ack;
            ST_HOLD:  retire_s = instr_accept;
            default: begin
                load_s   = 1'b0;
                retire_s = 1'b0;
            end
        endcase
    end

    assign pc_plus4_s = pc_q + 32'd4;
    assign jump_tgt_s = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
    assign br_off_s   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_tgt_s   = pc_plus4_s + br_off_s;

    // Next-PC priority: jump, then taken branch, then sequential.
    always_comb begin
        if (jump) begin
            next_pc_s = jump_tgt_s;
        end else if (branch && zero) begin
            next_pc_s = br_tgt_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Datapath next values; req/valid are registered copies of the upcoming state.
    always_comb begin
        if (retire_s) begin
            pc_d      = next_pc_s;
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d      = pc_q;
            retired_d = retired_q;
        end
        if (load_s) begin
            instr_d = imem_rdata;
        end else begin
            instr_d = instr_q;
        end
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_HOLD);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a bench-side memory/control responder, a cycle model
// derived from the fetch/hold rules, a per-cycle compare and directed literal checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_main = 1'b1;
    logic        rst_ack = 1'b0;
    logic        rst;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_accept = 1'b0;
    logic        jump = 1'b0, branch = 1'b0, zero = 1'b0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
    logic [5:0]  op_code, funct;

    logic        h_rst = 1'b1, h_imem_ack = 1'b0, h_instr_accept = 1'b0;
    logic        h_jump = 1'b0, h_branch = 1'b0, h_zero = 1'b0;
    logic [31:0] h_imem_rdata = 32'h0;
    logic        h_imem_req, h_instr_valid;
    logic [31:0] h_imem_addr, h_instr, h_pc, h_pc_plus4, h_retired;
    logic [5:0]  h_op_code, h_funct;

    int n_chk = 0;
    int n_err = 0;

    assign rst = rst_main | rst_ack;
    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .op_code(op_code), .funct(funct), .instr_valid(instr_valid),
        .instr_accept(instr_accept), .jump(jump), .branch(branch), .zero(zero),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0010), .CNT_W(32)) u_dut_hi (
        .clk(clk), .rst(h_rst), .imem_req(h_imem_req), .imem_addr(h_imem_addr),
        .imem_ack(h_imem_ack), .imem_rdata(h_imem_rdata), .instr(h_instr),
        .op_code(h_op_code), .funct(h_funct), .instr_valid(h_instr_valid),
        .instr_accept(h_instr_accept), .jump(h_jump), .branch(h_branch), .zero(h_zero),
        .pc(h_pc), .pc_plus4(h_pc_plus4), .retired(h_retired)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory / control-unit responder ----------------
    logic [31:0] mem [logic [31:0]];
    int  wait_n = 0, acc_delay = 0, wait_ctr = 0, hold_ctr = 0;
    logic zero_cfg = 1'b0, noise = 1'b1, rst_on_ack = 1'b0, rst_ack_done = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h2008_0005;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rst_ack      = 1'b0;
            imem_ack     = 1'b0;
            imem_rdata   = $urandom;
            instr_accept = 1'b0;
            if (imem_req) begin
                if (wait_ctr >= wait_n) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_ctr   = 0;
                    if (rst_on_ack && !rst_ack_done) begin
                        rst_ack      = 1'b1;
                        rst_ack_done = 1'b1;
                    end
                end else begin
                    wait_ctr++;
                end
            end else begin
                wait_ctr = 0;
                if (noise) imem_ack = 1'($urandom_range(0, 1));
            end
            if (instr_valid) begin
                if (hold_ctr >= acc_delay) begin
                    instr_accept = 1'b1;
                    hold_ctr     = 0;
                end else begin
                    hold_ctr++;
                end
            end else begin
                hold_ctr = 0;
                if (noise) instr_accept = 1'($urandom_range(0, 1));
            end
            jump   = (instr[31:26] == 6'd2);
            branch = (instr[31:26] == 6'd4);
            zero   = zero_cfg;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_ret;
    logic        m_valid, m_boot;
    logic        chk_en = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = p + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            imm = w[15:0];
            off = int'(imm);
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_valid <= 1'b0; m_ret <= 32'h0; m_boot <= 1'b1;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (!m_valid) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_valid <= 1'b1;
            end
        end else if (instr_accept) begin
            m_pc    <= model_next(m_pc, m_instr, jump, branch, zero);
            m_valid <= 1'b0;
            m_ret   <= m_ret + 32'd1;
        end
    end

    // Per-cycle compare against the model, plus fetch-address log.
    logic [31:0] addr_q[$];
    logic        prev_req = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", imem_req, !m_boot && !m_valid);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("op_code", op_code, m_instr >> 26);
            chk("funct", funct, m_instr & 32'h3F);
            chk("instr_valid", instr_valid, m_valid);
            chk("retired", retired, m_ret);
            if (imem_req && !prev_req) addr_q.push_back(imem_addr);
        end
        prev_req <= imem_req;
    end

    task automatic wait_ret(input logic [31:0] n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_ret != n && k < 300);
        if (m_ret != n) begin
            n_chk++; n_err++;
            $display("FAIL wait_ret timeout: got %0d expected %0d", m_ret, n);
        end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!instr_valid && k < 300);
        chk("wait_valid", instr_valid, 1'b1);
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!imem_req && k < 300);
        chk("wait_req", imem_req, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_main = 1'b1;
        @(posedge clk); #1 rst_main = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_op_code", op_code, 6'd0);
        @(posedge clk); #1 rst_main = 1'b0;

        // zero-wait memory, immediate accept
        wait_valid();
        chk("first_op_code", op_code, 6'b001000);
        chk("first_funct", funct, 6'd5);
        wait_ret(32'd3);
        chk("retired_3", retired, 32'd3);
        chk("addr_log_size", 32'(addr_q.size() >= 3), 32'd1);
        if (addr_q.size() >= 3) begin
            chk("addr_seq0", addr_q[0], 32'h0);
            chk("addr_seq1", addr_q[1], 32'h4);
            chk("addr_seq2", addr_q[2], 32'h8);
        end

        // three memory wait cycles
        wait_n = 3;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req) begin
                cnt++;
                chk("wait_addr", imem_addr, 32'h0);
            end
            if (instr_valid) break;
        end
        chk("wait_req_cycles", cnt, 32'd4);

        // branch taken / not taken at 0x100
        wait_n   = 0;
        mem[32'h0]   = 32'h0800_0040;
        mem[32'h100] = 32'h1000_FFFE;
        zero_cfg = 1'b1;
        do_reset();
        wait_ret(32'd2);
        chk("br_taken_addr", imem_addr, 32'h0000_00FC);
        chk("br_taken_req", imem_req, 1'b1);
        zero_cfg = 1'b0;
        wait_ret(32'd4);
        chk("br_not_taken_addr", imem_addr, 32'h0000_0104);

        // negative branch below 0 and pc_plus4 wrap
        mem[32'h0] = 32'h1000_FFFE;
        zero_cfg   = 1'b1;
        do_reset();
        wait_ret(32'd1);
        chk("neg_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("neg_wrap_plus4", pc_plus4, 32'h0);
        wait_ret(32'd2);
        chk("seq_wrap_addr", imem_addr, 32'h0);

        // accept held low for 5 HOLD cycles
        mem.delete(32'h0);
        zero_cfg  = 1'b0;
        acc_delay = 5;
        do_reset();
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_pc", pc, 32'h0);
            chk("hold_instr", instr, 32'h2008_0005);
            chk("hold_retired", retired, 32'd0);
            chk("hold_req", imem_req, 1'b0);
            @(negedge clk);
        end
        @(negedge clk);
        chk("hold_one_inc", retired, 32'd1);
        chk("hold_valid_drop", instr_valid, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_still_one", retired, 32'd1);
        acc_delay = 0;

        // reset in the same cycle as an ack
        wait_n         = 2;
        mem[32'h4]     = 32'h2108_0007;
        do_reset();
        wait_ret(32'd1);
        rst_on_ack = 1'b1;
        for (int i = 0; i < 50 && !rst_ack_done; i++) @(negedge clk);
        chk("rst_ack_fired", rst_ack_done, 1'b1);
        @(negedge clk);
        chk("rstack_instr", instr, 32'h0);
        chk("rstack_valid", instr_valid, 1'b0);
        chk("rstack_pc", pc, 32'h0);
        chk("rstack_req", imem_req, 1'b0);
        chk("rstack_retired", retired, 32'd0);
        wait_req();
        chk("rstack_first_addr", imem_addr, 32'h0);

        // jump beats branch, second instance at 0x4000_0010
        @(posedge clk); #1 h_rst = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!h_imem_req && cnt < 50);
        chk("hi_req", h_imem_req, 1'b1);
        chk("hi_first_addr", h_imem_addr, 32'h4000_0010);
        @(posedge clk); #1;
        h_imem_ack   = 1'b1;
        h_imem_rdata = 32'h0800_0040;
        @(posedge clk); #1;
        h_imem_ack     = 1'b0;
        h_instr_accept = 1'b1;
        h_jump = 1'b1; h_branch = 1'b1; h_zero = 1'b1;
        @(negedge clk);
        chk("hi_valid", h_instr_valid, 1'b1);
        @(posedge clk); #1 h_instr_accept = 1'b0;
        @(negedge clk);
        chk("hi_jump_addr", h_imem_addr, 32'h4000_0100);
        chk("hi_jump_req", h_imem_req, 1'b1);
        chk("hi_retired", h_retired, 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
